// File: rtl/cfcycle_ctl.sv
// Print-cycle sequencer for the 1052/2150 function decoder: accepts one EBCDIC
// byte, inserts shift-change and automatic carrier-return cycles, tracks the column.
module cfcycle_ctl #(
  parameter int CYCLE_CLKS = 4,
  parameter int LINE_LEN   = 126,
  parameter int TIMEOUT    = 65535
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_valid,
  input  logic [7:0] i_data,
  input  logic       i_lower,
  output logic       o_ack,
  output logic [7:0] o_data_reg,
  input  logic       i_function,
  output logic       o_cycle_time,
  output logic       o_case_latch,
  output logic       o_shift_change,
  output logic       o_ready,
  output logic       o_carrier_return_latch,
  input  logic       i_cb_done,
  output logic       o_busy,
  output logic       o_error,
  input  logic       i_clear_error,
  output logic [6:0] o_column
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_EVAL,
    S_SHIFT,
    S_TYPE,
    S_AUTOCR,
    S_ACK,
    S_ERROR
  } state_t;

  localparam int              PCW        = (CYCLE_CLKS > 1) ? $clog2(CYCLE_CLKS) : 1;
  localparam logic [PCW-1:0]  PULSE_LAST = PCW'(CYCLE_CLKS - 1);
  localparam logic [15:0]     WAIT_LAST  = 16'(TIMEOUT - 1);
  localparam logic [6:0]      LINE_END   = 7'(LINE_LEN);
  localparam logic [7:0]      BYTE_CR    = 8'h15;
  localparam logic [7:0]      BYTE_SPACE = 8'h40;

  state_t         state_q, state_d;
  logic           in_wait_q, in_wait_d;
  logic [PCW-1:0] pulse_cnt_q, pulse_cnt_d;
  logic [15:0]    wait_cnt_q, wait_cnt_d;
  logic [7:0]     data_q, data_d;
  logic           req_lower_q, req_lower_d;
  logic           tw_case_q, tw_case_d;
  logic [6:0]     column_q, column_d;
  logic           error_q, error_d;

  logic cycling;
  logic cycle_done;
  logic cycle_timeout;

  // The strobes below are decoded from registered state only, so an async
  // reset of the registers drops them without waiting for a clock edge.
  assign cycling       = (state_q == S_SHIFT) || (state_q == S_TYPE) || (state_q == S_AUTOCR);
  assign cycle_done    = cycling && in_wait_q && i_cb_done;
  assign cycle_timeout = cycling && in_wait_q && !i_cb_done && (wait_cnt_q == WAIT_LAST);

  assign o_cycle_time = cycling && !in_wait_q;
  assign o_data_reg   = data_q;
  assign o_column     = column_q;
  assign o_busy       = (state_q != S_IDLE);
  assign o_error      = error_q;

  always_comb begin
    // NOTE: every variable written here gets a default first, otherwise a path
    // that skips the assignment would infer a latch.
    state_d                = state_q;
    in_wait_d              = in_wait_q;
    pulse_cnt_d            = pulse_cnt_q;
    wait_cnt_d             = wait_cnt_q;
    data_d                 = data_q;
    req_lower_d            = req_lower_q;
    tw_case_d              = tw_case_q;
    column_d               = column_q;
    error_d                = error_q;
    o_ack                  = 1'b0;
    o_shift_change         = 1'b0;
    o_ready                = 1'b0;
    o_carrier_return_latch = 1'b0;
    o_case_latch           = tw_case_q;

    // Shared cycle timer: pulse phase, then wait phase for the cycle-complete contact.
    if (cycling) begin
      if (!in_wait_q) begin
        if (pulse_cnt_q == PULSE_LAST) begin
          in_wait_d  = 1'b1;
          wait_cnt_d = '0;
        end else begin
          pulse_cnt_d = pulse_cnt_q + PCW'(1);
        end
      end else if (!i_cb_done) begin
        wait_cnt_d = wait_cnt_q + 16'(1);
      end
    end

    unique case (state_q)
      S_IDLE: begin
        if (i_valid) begin
          data_d      = i_data;
          req_lower_d = i_lower;
          state_d     = S_EVAL;
        end
      end
      S_EVAL: begin
        if ((column_q == LINE_END) && (data_q != BYTE_CR)) begin
          state_d = S_AUTOCR;
        end else if (!i_function && (req_lower_q != tw_case_q)) begin
          state_d = S_SHIFT;
        end else begin
          state_d = S_TYPE;
        end
      end
      S_SHIFT: begin
        o_shift_change = 1'b1;
        o_ready        = 1'b1;
        o_case_latch   = req_lower_q;
        if (cycle_done) begin
          tw_case_d = req_lower_q;
          state_d   = S_TYPE;
        end
      end
      S_TYPE: begin
        if (cycle_done) begin
          if (data_q == BYTE_CR) begin
            column_d = '0;
          end else if ((data_q == BYTE_SPACE) || !i_function) begin
            if (column_q != LINE_END) column_d = column_q + 7'(1);
          end
          state_d = S_ACK;
        end
      end
      S_AUTOCR: begin
        o_carrier_return_latch = 1'b1;
        if (cycle_done) begin
          column_d = '0;
          state_d  = S_EVAL;
        end
      end
      S_ACK: begin
        o_ack   = 1'b1;
        state_d = S_IDLE;
      end
      S_ERROR: begin
        if (i_clear_error) begin
          error_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (cycle_timeout) begin
      error_d = 1'b1;
      state_d = S_ERROR;
    end

    // Each new state starts with a fresh cycle timer.
    if (state_d != state_q) begin
      in_wait_d   = 1'b0;
      pulse_cnt_d = '0;
      wait_cnt_d  = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values computed above.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q     <= S_IDLE;
      in_wait_q   <= 1'b0;
      pulse_cnt_q <= '0;
      wait_cnt_q  <= '0;
      data_q      <= 8'h00;
      req_lower_q <= 1'b1;
      tw_case_q   <= 1'b1;
      column_q    <= '0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_wait_q   <= in_wait_d;
      pulse_cnt_q <= pulse_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      data_q      <= data_d;
      req_lower_q <= req_lower_d;
      tw_case_q   <= tw_case_d;
      column_q    <= column_d;
      error_q     <= error_d;
    end
  end

endmodule
